// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the multicycle datapath, the load/store controller and the 64-bit data memory.
// Signal names follow the datapath's naming so the controller ports read like the memory-side schematic.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 64
);
  // Handshake: REQ is sampled only while the controller is idle, and the request fields are latched on that cycle.
  // BUSY stays high until the controller returns to idle. DONE is a single-cycle pulse, and MISALIGN is
  // meaningful only while DONE is high. A REQ raised while BUSY is dropped, not queued.
  logic              REQ;
  logic              WE;
  logic [2:0]        FUNCT3;
  logic [ADDR_W-1:0] ADDR;
  logic [63:0]       WDATA;
  logic [63:0]       RDATA;
  logic              DONE;
  logic              BUSY;
  logic              MISALIGN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [63:0]       MEM_DIN;
  logic [63:0]       MEM_DOUT;
  logic              MEM_WR;

  modport master (
    output REQ, WE, FUNCT3, ADDR, WDATA, MEM_DOUT,
    input  RDATA, DONE, BUSY, MISALIGN, MEM_ADDR, MEM_DIN, MEM_WR
  );

  modport slave (
    input  REQ, WE, FUNCT3, ADDR, WDATA, MEM_DOUT,
    output RDATA, DONE, BUSY, MISALIGN, MEM_ADDR, MEM_DIN, MEM_WR
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store controller: b/h/w/d accesses to a 64-bit little-endian memory, with read-modify-write for narrow stores.
// Optional macro DMEM_MISALIGN_CHECK_EN enables misalignment reporting; otherwise offsets round down to the access size.
module dmem_access_ctrl #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  dmem_access_ctrl_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [63:0]       din_q, din_d;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic              mis_q, mis_d;
`endif

  logic [2:0]  req_f3;
  logic [2:0]  req_off;
  logic        req_mis;
  logic [63:0] mask;
  logic [5:0]  shamt;
  logic [63:0] field;
  logic        field_msb;
  logic [63:0] load_val;
  logic [63:0] merge_val;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Request decode: effective funct3, byte offset and the alignment verdict.
  always_comb begin
    req_f3  = bus.FUNCT3;
    req_off = bus.ADDR[2:0];
    req_mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    case (bus.FUNCT3[1:0])
      2'd1:    req_mis = bus.ADDR[0];
      2'd2:    req_mis = |bus.ADDR[1:0];
      2'd3:    req_mis = |bus.ADDR[2:0];
      default: req_mis = 1'b0;
    endcase
    if (bus.FUNCT3 == 3'b111) req_mis = 1'b1;
`else
    if (bus.FUNCT3 == 3'b111) req_f3 = 3'b011;
    case (req_f3[1:0])
      2'd1:    req_off = {bus.ADDR[2:1], 1'b0};
      2'd2:    req_off = {bus.ADDR[2], 2'b00};
      2'd3:    req_off = 3'b000;
      default: req_off = bus.ADDR[2:0];
    endcase
`endif
  end

  // Lane extraction for loads and byte-lane merge for narrow stores, both on the latched request.
  always_comb begin
    mask  = size_mask(f3_q[1:0]);
    shamt = {off_q, 3'b000};
    field = (bus.MEM_DOUT >> shamt) & mask;
    case (f3_q[1:0])
      2'd0:    field_msb = field[7];
      2'd1:    field_msb = field[15];
      2'd2:    field_msb = field[31];
      default: field_msb = 1'b0;
    endcase
    load_val  = (!f3_q[2] && field_msb) ? (field | ~mask) : field;
    merge_val = (bus.MEM_DOUT & ~(mask << shamt)) | ((wdata_q << shamt) & (mask << shamt));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    din_d   = din_q;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          addr_d  = {bus.ADDR[ADDR_W-1:3], 3'b000};
          off_d   = req_off;
          f3_d    = req_f3;
          we_d    = bus.WE;
          wdata_d = bus.WDATA;
          cnt_d   = LAT_INIT;
`ifdef DMEM_MISALIGN_CHECK_EN
          mis_d   = req_mis;
`endif
          if (req_mis) begin
            state_d = RESP;
          end else if (bus.WE && req_f3[1:0] == 2'd3) begin
            din_d   = bus.WDATA;
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (we_q) begin
            din_d   = merge_val;
            state_d = WRITE;
          end else begin
            rdata_d = load_val;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      din_q   <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus.RDATA    = rdata_q;
  assign bus.DONE     = (state_q == RESP);
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.MEM_ADDR = addr_q;
  assign bus.MEM_DIN  = din_q;
  assign bus.MEM_WR   = (state_q == WRITE);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.MISALIGN = (state_q == RESP) && mis_q;
`else
  assign bus.MISALIGN = 1'b0;
`endif
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, busy/reset sequences, and random traffic checked
// against a byte-array reference model.
module tb_dmem_access_ctrl;
  localparam int L  = 1;
  localparam int AW = 64;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  dmem_access_ctrl_if #(.ADDR_W(AW)) bus ();

  dmem_access_ctrl #(.READ_LAT(L), .ADDR_W(AW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Memory: 32 doublewords; read data appears L cycles after the address edge.
  logic [63:0] mem [32];
  logic [63:0] rd_pipe [4];
  int          wr_cnt = 0;

  always @(posedge CLK) begin
    if (bus.MEM_WR) begin
      mem[bus.MEM_ADDR[7:3]] <= bus.MEM_DIN;
      wr_cnt <= wr_cnt + 1;
    end
    rd_pipe[0] <= mem[bus.MEM_ADDR[7:3]];
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  if (L == 1) begin : g_rd_comb
    assign bus.MEM_DOUT = mem[bus.MEM_ADDR[7:3]];
  end else begin : g_rd_pipe
    assign bus.MEM_DOUT = rd_pipe[L-2];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory plus the last load result.
  logic [7:0]  mb [256];
  logic [63:0] m_rdata = '0;

  typedef struct {
    logic [63:0] rdata;
    int          lat;
    logic        mis;
    int          wr;
    logic [63:0] din;
  } exp_t;

  task automatic model_access(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                              input logic [63:0] wd, output exp_t e);
    int size, off, base;
    logic mis;
    logic [63:0] v;
    base = int'(addr) & ~7;
    off  = int'(addr) % 8;
    size = (f3 == 3'b111) ? 8 : (1 << f3[1:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (f3 == 3'b111) || (off % size != 0);
`else
    mis = 1'b0;
    off = off - (off % size);
`endif
    e.mis = mis;
    e.din = '0;
    e.wr  = 0;
    if (mis) begin
      e.lat = 1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[base + off + i];
      if (f3 < 3'd3 && v[8*size-1])
        for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
      m_rdata = v;
      e.lat   = L + 1;
    end else begin
      for (int i = 0; i < size; i++) mb[base + off + i] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++) e.din[8*i +: 8] = mb[base + i];
      e.wr  = 1;
      e.lat = (size == 8) ? 2 : L + 2;
    end
    e.rdata = m_rdata;
  endtask

  typedef struct {
    logic [63:0] rdata;
    int          lat;
    logic        mis;
    int          wr;
    logic [63:0] din;
    logic [63:0] maddr;
    logic        busy_after;
  } obs_t;

  // Starts and ends at a negedge in an idle cycle; scrambles the inputs after acceptance.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [63:0] wd, output obs_t o);
    int start_wr, cyc;
    start_wr   = wr_cnt;
    bus.REQ    = 1'b1;
    bus.WE     = we;
    bus.FUNCT3 = f3;
    bus.ADDR   = 64'(addr);
    bus.WDATA  = wd;
    @(posedge CLK); @(negedge CLK);
    bus.REQ    = 1'b0;
    bus.WE     = 1'($urandom_range(0, 1));
    bus.FUNCT3 = 3'($urandom_range(0, 7));
    bus.ADDR   = 64'($urandom_range(0, 255));
    bus.WDATA  = {$urandom, $urandom};
    o.din = '0;
    cyc   = 1;
    while (!bus.DONE && cyc < 20) begin
      if (bus.MEM_WR) o.din = bus.MEM_DIN;
      @(posedge CLK); @(negedge CLK);
      cyc++;
    end
    o.lat   = bus.DONE ? cyc : -1;
    o.rdata = bus.RDATA;
    o.mis   = bus.MISALIGN;
    o.maddr = bus.MEM_ADDR;
    @(posedge CLK); @(negedge CLK);
    o.wr         = wr_cnt - start_wr;
    o.busy_after = bus.BUSY;
  endtask

  task automatic run_checked(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                             input logic [63:0] wd);
    exp_t e;
    obs_t o;
    model_access(we, f3, addr, wd, e);
    run_txn(we, f3, addr, wd, o);
    chk("rnd_lat",   64'(o.lat),   64'(e.lat));
    chk("rnd_mis",   64'(o.mis),   64'(e.mis));
    chk("rnd_rdata", o.rdata,      e.rdata);
    chk("rnd_wr",    64'(o.wr),    64'(e.wr));
    chk("rnd_maddr", o.maddr,      64'(addr & 8'hF8));
    chk("rnd_idle",  64'(o.busy_after), 64'd0);
    if (e.wr == 1) chk("rnd_din", o.din, e.din);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          lat;
    logic        mis;
    int          wr;
    logic [63:0] din;
  } vec_t;

  vec_t vt [14];

  initial begin
    exp_t e;
    obs_t o;
    int   start_wr, cyc;

    vt[0]  = '{0, 3'b000, 8'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, L+1, 0, 0, 64'h0};
    vt[1]  = '{0, 3'b100, 8'h17, 64'h0, 64'h0000_0000_0000_0088, L+1, 0, 0, 64'h0};
    vt[2]  = '{0, 3'b010, 8'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, L+1, 0, 0, 64'h0};
    vt[3]  = '{0, 3'b110, 8'h14, 64'h0, 64'h0000_0000_8877_6655, L+1, 0, 0, 64'h0};
    vt[4]  = '{1, 3'b001, 8'h12, 64'h1234_ABCD, 64'h0000_0000_8877_6655, L+2, 0, 1, 64'h8877_6655_ABCD_2211};
    vt[5]  = '{1, 3'b011, 8'h18, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_8877_6655, 2, 0, 1, 64'hDEAD_BEEF_0000_0001};
    vt[6]  = '{0, 3'b011, 8'h18, 64'h0, 64'hDEAD_BEEF_0000_0001, L+1, 0, 0, 64'h0};
    vt[7]  = '{0, 3'b001, 8'h12, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, L+1, 0, 0, 64'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
    vt[8]  = '{0, 3'b010, 8'h12, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 1, 1, 0, 64'h0};
    vt[9]  = '{0, 3'b111, 8'h10, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 1, 1, 0, 64'h0};
`else
    vt[8]  = '{0, 3'b010, 8'h12, 64'h0, 64'hFFFF_FFFF_ABCD_2211, L+1, 0, 0, 64'h0};
    vt[9]  = '{0, 3'b111, 8'h10, 64'h0, 64'h8877_6655_ABCD_2211, L+1, 0, 0, 64'h0};
`endif
    vt[10] = '{0, 3'b101, 8'h16, 64'h0, 64'h0000_0000_0000_8877, L+1, 0, 0, 64'h0};
    vt[11] = '{1, 3'b000, 8'h13, 64'h5A, 64'h0000_0000_0000_8877, L+2, 0, 1, 64'h8877_6655_5ACD_2211};
    vt[12] = '{0, 3'b000, 8'h13, 64'h0, 64'h0000_0000_0000_005A, L+1, 0, 0, 64'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
    vt[13] = '{1, 3'b010, 8'h11, 64'h0BAD_F00D, 64'h5A, 1, 1, 0, 64'h0};
`else
    vt[13] = '{1, 3'b010, 8'h11, 64'h0BAD_F00D, 64'h5A, L+2, 0, 1, 64'h8877_6655_0BAD_F00D};
`endif

    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[2] = 64'h8877_6655_4433_2211;
    for (int i = 0; i < 256; i++) mb[i] = mem[i/8][8*(i%8) +: 8];

    bus.REQ = 1'b0; bus.WE = 1'b0; bus.FUNCT3 = '0; bus.ADDR = '0; bus.WDATA = '0;
    RESET = 1'b1;
    #1;
    chk("rst_rdata",    bus.RDATA,           64'h0);
    chk("rst_done",     64'(bus.DONE),       64'h0);
    chk("rst_busy",     64'(bus.BUSY),       64'h0);
    chk("rst_misalign", 64'(bus.MISALIGN),   64'h0);
    chk("rst_mem_wr",   64'(bus.MEM_WR),     64'h0);
    chk("rst_mem_addr", bus.MEM_ADDR,        64'h0);
    chk("rst_mem_din",  bus.MEM_DIN,         64'h0);
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      model_access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, e);
      run_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, o);
      chk($sformatf("vec%0d_lat", i),   64'(o.lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_rdata", i), o.rdata,    vt[i].rd);
      chk($sformatf("vec%0d_mis", i),   64'(o.mis), 64'(vt[i].mis));
      chk($sformatf("vec%0d_wr", i),    64'(o.wr),  64'(vt[i].wr));
      chk($sformatf("vec%0d_maddr", i), o.maddr,    64'(vt[i].addr & 8'hF8));
      if (vt[i].wr == 1) chk($sformatf("vec%0d_din", i), o.din, vt[i].din);
    end

    // REQ held high while busy must neither be queued nor start a write.
    model_access(1'b0, 3'b000, 8'h17, 64'h0, e);
    start_wr   = wr_cnt;
    bus.REQ    = 1'b1; bus.WE = 1'b0; bus.FUNCT3 = 3'b000; bus.ADDR = 64'h17;
    @(posedge CLK); @(negedge CLK);
    chk("busy_during", 64'(bus.BUSY), 64'h1);
    bus.WE = 1'b1; bus.FUNCT3 = 3'b011; bus.ADDR = 64'h10; bus.WDATA = 64'h0;
    cyc = 1;
    while (!bus.DONE && cyc < 20) begin
      @(posedge CLK); @(negedge CLK);
      cyc++;
    end
    bus.REQ = 1'b0;
    chk("busy_lat",   64'(cyc), 64'(L + 1));
    chk("busy_rdata", bus.RDATA, e.rdata);
    @(posedge CLK); @(negedge CLK);
    chk("busy_idle",  64'(bus.BUSY), 64'h0);
    chk("busy_no_wr", 64'(wr_cnt - start_wr), 64'h0);

    // Reset in the middle of a read-modify-write.
    start_wr   = wr_cnt;
    bus.REQ    = 1'b1; bus.WE = 1'b1; bus.FUNCT3 = 3'b000; bus.ADDR = 64'h10; bus.WDATA = 64'hEE;
    @(posedge CLK); @(negedge CLK);
    bus.REQ = 1'b0;
    chk("rmw_busy", 64'(bus.BUSY), 64'h1);
    RESET = 1'b1;
    #1;
    chk("rmw_rst_busy",  64'(bus.BUSY),   64'h0);
    chk("rmw_rst_wr",    64'(bus.MEM_WR), 64'h0);
    chk("rmw_rst_rdata", bus.RDATA,       64'h0);
    chk("rmw_rst_maddr", bus.MEM_ADDR,    64'h0);
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b0;
    m_rdata = '0;
    @(negedge CLK);
    chk("rmw_no_wr", 64'(wr_cnt - start_wr), 64'h0);
    run_checked(1'b0, 3'b011, 8'h10, 64'h0);

    for (int i = 0; i < 200; i++)
      run_checked(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), {$urandom, $urandom});

    for (int i = 0; i < 32; i++) run_checked(1'b0, 3'b011, 8'(i * 8), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Load/store access controller between the multicycle datapath and the 64-bit data memory. It takes a request from the control unit, with the address from the ALU output register and store data from register B. It then performs a byte, half, word or doubleword access, using read-modify-write for sub-doubleword stores. The sign- or zero-extended load result goes to the memory data register, and completion is reported with a handshake.

Parameters:
READ_LAT, 1, data-memory read latency in cycles (1..4); MEM_DOUT valid READ_LAT cycles after MEM_ADDR is presented.
ADDR_W, 64, address width.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
REQ  input  1  access request; sampled only in IDLE
WE  input  1  1 = store, 0 = load
FUNCT3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
ADDR  input  ADDR_W  byte address
WDATA  input  64  store data; right-aligned
RDATA  output  64  extended load result
DONE  output  1  one-cycle completion pulse
BUSY  output  1  high in every state other than IDLE
MISALIGN  output  1  qualifies DONE; access was misaligned
MEM_ADDR  output  ADDR_W  doubleword-aligned address {ADDR[ADDR_W-1:3],3'b000}
MEM_DIN  output  64  write data to memory
MEM_DOUT  input  64  read data from memory
MEM_WR  output  1  memory write enable; 1 = write, 0 = read

Behaviour:
- Memory is little-endian. The byte offset is off = ADDR[2:0].
- Latched at REQ acceptance: ADDR, WE, FUNCT3, WDATA. Later input changes are ignored until DONE.
- Reset values: RDATA=0, DONE=0, BUSY=0, MISALIGN=0, MEM_WR=0, MEM_ADDR=0, MEM_DIN=0, state=IDLE.
- Alignment rule: an access is misaligned when off is not a multiple of the size (h: off[0]; w: off[1:0]; d: off[2:0]). FUNCT3=111 is also treated as misaligned.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- IDLE, REQ=1, misaligned -> RESP with MISALIGN=1. No memory access. RDATA holds its previous value.
- IDLE, REQ=1, load or sub-doubleword store -> RD_WAIT. A counter runs for READ_LAT cycles. MEM_DOUT is captured at the end of the last RD_WAIT cycle.
- IDLE, REQ=1, store with FUNCT3=011 -> WRITE directly (no read).
- RD_WAIT done, load -> RESP. RDATA = extracted field: bytes [off*8 +: size*8], sign-extended for 000/001/010 and zero-extended for 100/101/110/011. RDATA updates in the RESP cycle.
- RD_WAIT done, store -> WRITE. MEM_DIN = captured doubleword with bytes [off .. off+size-1] replaced by the low size bytes of WDATA. All other bytes are bit-identical to the captured data.
- WRITE: MEM_WR=1 for exactly one cycle. For sd, MEM_DIN=WDATA. Next state is RESP.
- RESP: DONE=1 for one cycle; MISALIGN is valid in this cycle only, otherwise 0. Next state is IDLE.
- Latency from the REQ cycle to DONE with READ_LAT=L:
  - load: L+1
  - sd: 2
  - sb/sh/sw: L+2
  - misaligned: 1
- Back-to-back: a new REQ is accepted in the IDLE cycle immediately after RESP. REQ while BUSY is ignored, not queued.
- MEM_ADDR holds the latched aligned address from the cycle after acceptance through RESP. MEM_WR is 0 outside WRITE.
- RESET asserted in any state: immediate return to IDLE and outputs to reset values. A pending RMW write is abandoned and MEM_WR drops asynchronously; memory is never partially written.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: alignment rule and the MISALIGN output behave as above.
- Undefined: no alignment check. MISALIGN is tied to 0 and FUNCT3=111 behaves as 011. The offset used for extraction and merge is forced down to the size boundary (off & ~(size-1)). A misaligned access therefore proceeds on the containing aligned field.

Test Plan:
- Memory[0x10]=0x8877665544332211, READ_LAT=1. lb ADDR=0x17, REQ at cycle 0 -> DONE at cycle 2, RDATA=0xFFFFFFFFFFFFFF88, MISALIGN=0, MEM_WR never 1.
- Same memory. lbu 0x17 -> RDATA=0x0000000000000088. lw 0x14 -> 0xFFFFFFFF88776655. lwu 0x14 -> 0x0000000088776655.
- sh ADDR=0x12, WDATA=0x1234ABCD -> one read, then MEM_WR=1 for exactly one cycle with MEM_DIN=0x88776655ABCD2211; DONE at cycle 3.
- sd ADDR=0x18, WDATA=0xDEADBEEF00000001 -> no RD_WAIT, MEM_WR at cycle 1, DONE at cycle 2; readback ld 0x18 returns the same value.
- With DMEM_MISALIGN_CHECK_EN defined: lw ADDR=0x12 -> DONE and MISALIGN at cycle 1, no MEM_WR, RDATA unchanged. A REQ pulsed during BUSY of a prior access is ignored.
- sb 0x10 with RESET asserted mid RD_WAIT -> BUSY=0 immediately, no MEM_WR; memory still reads 0x8877665544332211.
